pmmu_arbiter: RTL and testbench

//  Two-port arbiter sharing the single Pmmu memory port between the core
//  (ControlMatrix fetch/load/store, port 0) and the debug/loader port (port 1).

---
 rtl/pmmu_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_pmmu_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmmu_arbiter.sv
// pmmu_arbiter: two-port round-robin arbiter in front of the single Pmmu port.
// Port 0 is the core, port 1 the debug/loader. One access at a time:
// IDLE -> ACCESS (strobes until mem_rdy_i or watchdog expiry) -> DONE (ack) -> IDLE.
module pmmu_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  p0_req_i,
  input  logic                  p0_wr_i,
  input  logic [DATA_WIDTH-1:0] p0_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_wd_i,
  input  logic [2:0]            p0_funct3_i,
  output logic                  p0_ack_o,
  output logic [DATA_WIDTH-1:0] p0_rd_o,
  input  logic                  p1_req_i,
  input  logic                  p1_wr_i,
  input  logic [DATA_WIDTH-1:0] p1_addr_i,
  input  logic [DATA_WIDTH-1:0] p1_wd_i,
  input  logic [2:0]            p1_funct3_i,
  output logic                  p1_ack_o,
  output logic [DATA_WIDTH-1:0] p1_rd_o,
  output logic                  err_o,
  output logic                  grant_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wd_o,
  output logic [2:0]            mem_funct3_o,
  output logic                  mem_wr_o,
  output logic                  mem_rd_o,
  input  logic                  mem_rdy_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  localparam int unsigned DW  = DATA_WIDTH;
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]     r_state, w_state_n;
  logic           r_grant, w_grant_n;
  logic           r_last,  w_last_n;
  logic [DW-1:0]  r_addr,  w_addr_n;
  logic [DW-1:0]  r_wd,    w_wd_n;
  logic [2:0]     r_f3,    w_f3_n;
  logic           r_wr,    w_wr_n;
  logic [WDW-1:0] r_cnt,   w_cnt_n;
  logic           r_mem_rd, w_mem_rd_n;
  logic           r_mem_wr, w_mem_wr_n;
  logic           r_p0_ack, w_p0_ack_n;
  logic           r_p1_ack, w_p1_ack_n;
  logic [DW-1:0]  r_p0_rd,  w_p0_rd_n;
  logic [DW-1:0]  r_p1_rd,  w_p1_rd_n;
  logic           r_err,    w_err_n;

  logic           w_win;
  logic           w_sel_wr;
  logic [DW-1:0]  w_rdata;

  // Winner selection: a lone requester wins; on a tie the port that did not go last wins
  assign w_win    = (p0_req_i & p1_req_i) ? ~r_last : p1_req_i;
  assign w_sel_wr = w_win ? p1_wr_i : p0_wr_i;
  assign w_rdata  = r_wr ? '0 : mem_data_i;

  // Next-state and next-output logic
  always_comb begin
    w_state_n  = r_state;
    w_grant_n  = r_grant;
    w_last_n   = r_last;
    w_addr_n   = r_addr;
    w_wd_n     = r_wd;
    w_f3_n     = r_f3;
    w_wr_n     = r_wr;
    w_cnt_n    = r_cnt;
    w_mem_rd_n = 1'b0;
    w_mem_wr_n = 1'b0;
    w_p0_ack_n = 1'b0;
    w_p1_ack_n = 1'b0;
    w_p0_rd_n  = '0;
    w_p1_rd_n  = '0;
    w_err_n    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (p0_req_i | p1_req_i) begin
          w_grant_n  = w_win;
          w_addr_n   = w_win ? p1_addr_i   : p0_addr_i;
          w_wd_n     = w_win ? p1_wd_i     : p0_wd_i;
          w_f3_n     = w_win ? p1_funct3_i : p0_funct3_i;
          w_wr_n     = w_sel_wr;
          w_cnt_n    = '0;
          w_mem_rd_n = ~w_sel_wr;
          w_mem_wr_n = w_sel_wr;
          w_state_n  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mem_rdy_i) begin
          w_state_n = S_DONE;
          if (r_grant) begin
            w_p1_ack_n = 1'b1;
            w_p1_rd_n  = w_rdata;
          end else begin
            w_p0_ack_n = 1'b1;
            w_p0_rd_n  = w_rdata;
          end
        end else if (r_cnt == WD_LAST) begin
          // Watchdog expiry: complete with zero data and flag the error
          w_state_n = S_DONE;
          w_err_n   = 1'b1;
          if (r_grant) begin
            w_p1_ack_n = 1'b1;
          end else begin
            w_p0_ack_n = 1'b1;
          end
        end else begin
          w_cnt_n    = r_cnt + WDW'(1);
          w_mem_rd_n = ~r_wr;
          w_mem_wr_n = r_wr;
        end
      end
      S_DONE: begin
        w_last_n  = r_grant;
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= S_IDLE;
      r_grant  <= 1'b0;
      r_last   <= 1'b1;
      r_addr   <= '0;
      r_wd     <= '0;
      r_f3     <= '0;
      r_wr     <= 1'b0;
      r_cnt    <= '0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      r_p0_ack <= 1'b0;
      r_p1_ack <= 1'b0;
      r_p0_rd  <= '0;
      r_p1_rd  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_grant  <= w_grant_n;
      r_last   <= w_last_n;
      r_addr   <= w_addr_n;
      r_wd     <= w_wd_n;
      r_f3     <= w_f3_n;
      r_wr     <= w_wr_n;
      r_cnt    <= w_cnt_n;
      r_mem_rd <= w_mem_rd_n;
      r_mem_wr <= w_mem_wr_n;
      r_p0_ack <= w_p0_ack_n;
      r_p1_ack <= w_p1_ack_n;
      r_p0_rd  <= w_p0_rd_n;
      r_p1_rd  <= w_p1_rd_n;
      r_err    <= w_err_n;
    end
  end

  assign p0_ack_o     = r_p0_ack;
  assign p1_ack_o     = r_p1_ack;
  assign p0_rd_o      = r_p0_rd;
  assign p1_rd_o      = r_p1_rd;
  assign err_o        = r_err;
  assign grant_o      = r_grant;
  assign mem_addr_o   = r_addr;
  assign mem_wd_o     = r_wd;
  assign mem_funct3_o = r_f3;
  assign mem_wr_o     = r_mem_wr;
  assign mem_rd_o     = r_mem_rd;

endmodule

// File: tb/tb_pmmu_arbiter.sv
// Bench for pmmu_arbiter: directed scenarios plus randomized traffic, with a
// transaction-level reference model compared against the DUT every cycle.
module tb_pmmu_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  logic          clk;
  logic          reset_i;
  logic          p0_req_i, p0_wr_i, p1_req_i, p1_wr_i;
  logic [DW-1:0] p0_addr_i, p0_wd_i, p1_addr_i, p1_wd_i;
  logic [2:0]    p0_funct3_i, p1_funct3_i;
  logic          p0_ack_o, p1_ack_o, err_o, grant_o, mem_wr_o, mem_rd_o;
  logic [DW-1:0] p0_rd_o, p1_rd_o, mem_addr_o, mem_wd_o;
  logic [2:0]    mem_funct3_o;
  logic          mem_rdy_i;
  logic [DW-1:0] mem_data_i;

  pmmu_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .p0_req_i(p0_req_i), .p0_wr_i(p0_wr_i), .p0_addr_i(p0_addr_i), .p0_wd_i(p0_wd_i),
    .p0_funct3_i(p0_funct3_i), .p0_ack_o(p0_ack_o), .p0_rd_o(p0_rd_o),
    .p1_req_i(p1_req_i), .p1_wr_i(p1_wr_i), .p1_addr_i(p1_addr_i), .p1_wd_i(p1_wd_i),
    .p1_funct3_i(p1_funct3_i), .p1_ack_o(p1_ack_o), .p1_rd_o(p1_rd_o),
    .err_o(err_o), .grant_o(grant_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_funct3_o(mem_funct3_o),
    .mem_wr_o(mem_wr_o), .mem_rd_o(mem_rd_o),
    .mem_rdy_i(mem_rdy_i), .mem_data_i(mem_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic          exp_p0_ack, exp_p1_ack, exp_err, exp_grant, exp_mrd, exp_mwr;
  logic [DW-1:0] exp_addr, exp_wd, exp_p0_rd, exp_p1_rd;
  logic [2:0]    exp_f3;
  logic          m_last, m_own, m_wr, m_ok;
  bit            m_busy, m_aborted;
  int            m_wait;
  logic [DW-1:0] m_rd;

  task automatic model_reset();
    exp_p0_ack = 1'b0; exp_p1_ack = 1'b0; exp_err = 1'b0; exp_grant = 1'b0;
    exp_mrd = 1'b0; exp_mwr = 1'b0; exp_addr = '0; exp_wd = '0; exp_f3 = '0;
    exp_p0_rd = '0; exp_p1_rd = '0; m_last = 1'b1;
  endtask

  initial begin : model
    model_reset();
    forever begin
      @(posedge clk);
      if (reset_i) begin
        model_reset();
      end else if (p0_req_i || p1_req_i) begin
        m_own    = (p0_req_i && p1_req_i) ? !m_last : p1_req_i;
        m_wr     = m_own ? p1_wr_i : p0_wr_i;
        exp_addr = m_own ? p1_addr_i : p0_addr_i;
        exp_wd   = m_own ? p1_wd_i : p0_wd_i;
        exp_f3   = m_own ? p1_funct3_i : p0_funct3_i;
        exp_grant = m_own;
        exp_mrd  = !m_wr;
        exp_mwr  = m_wr;
        m_wait = 0; m_busy = 1'b1; m_aborted = 1'b0; m_ok = 1'b0;
        while (m_busy) begin
          @(posedge clk);
          if (reset_i) begin
            model_reset();
            m_busy = 1'b0; m_aborted = 1'b1;
          end else begin
            if (mem_rdy_i) begin
              m_busy = 1'b0; m_ok = 1'b1;
            end else begin
              m_wait++;
              if (m_wait == int'(TMO)) begin
                m_busy = 1'b0; m_ok = 1'b0;
              end
            end
            if (!m_busy) begin
              exp_mrd = 1'b0; exp_mwr = 1'b0;
              m_rd    = (m_ok && !m_wr) ? mem_data_i : 32'd0;
              exp_err = !m_ok;
              if (m_own) begin exp_p1_ack = 1'b1; exp_p1_rd = m_rd; end
              else       begin exp_p0_ack = 1'b1; exp_p0_rd = m_rd; end
            end
          end
        end
        if (!m_aborted) begin
          @(posedge clk);
          if (reset_i) begin
            model_reset();
          end else begin
            exp_p0_ack = 1'b0; exp_p1_ack = 1'b0; exp_err = 1'b0;
            exp_p0_rd = '0; exp_p1_rd = '0;
            m_last = m_own;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctl{ack0,ack1,err,grant,mwr,mrd}",
          {26'd0, p0_ack_o, p1_ack_o, err_o, grant_o, mem_wr_o, mem_rd_o},
          {26'd0, exp_p0_ack, exp_p1_ack, exp_err, exp_grant, exp_mwr, exp_mrd});
      chk("mem_addr", mem_addr_o, exp_addr);
      chk("mem_wd", mem_wd_o, exp_wd);
      chk("mem_funct3", {29'd0, mem_funct3_o}, {29'd0, exp_f3});
      chk("p0_rd", p0_rd_o, exp_p0_rd);
      chk("p1_rd", p1_rd_o, exp_p1_rd);
    end
  end

  // ---------------- directed access helper ----------------
  int            d_strobes, d_acks, d_oth;
  logic [DW-1:0] d_rd, d_addr, d_wd, d_exp_rd;
  logic [2:0]    d_f3;
  logic          d_err, d_grant, d_exp_err, d_wr_seen, d_rd_seen;

  task automatic set_port(input bit p, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] f3);
    if (p) begin
      p1_req_i = 1'b1; p1_wr_i = wr; p1_addr_i = addr; p1_wd_i = wd; p1_funct3_i = f3;
    end else begin
      p0_req_i = 1'b1; p0_wr_i = wr; p0_addr_i = addr; p0_wd_i = wd; p0_funct3_i = f3;
    end
  endtask

  task automatic dir_access(input bit p, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [2:0] f3,
                            input int rdy_at, input logic [31:0] rdata);
    bit done, strobe, own_ack, oth_ack;
    d_strobes = 0; d_acks = 0; d_oth = 0; d_rd = '1; d_addr = '0; d_wd = '0; d_f3 = '0;
    d_err = 1'bx; d_grant = 1'bx; d_exp_rd = '1; d_exp_err = 1'bx;
    d_wr_seen = 1'b0; d_rd_seen = 1'b0;
    set_port(p, wr, addr, wd, f3);
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      strobe = mem_rd_o | mem_wr_o;
      if (strobe) begin
        d_strobes++;
        d_addr = mem_addr_o; d_wd = mem_wd_o; d_f3 = mem_funct3_o;
        d_wr_seen = d_wr_seen | mem_wr_o; d_rd_seen = d_rd_seen | mem_rd_o;
      end
      own_ack = p ? p1_ack_o : p0_ack_o;
      oth_ack = p ? p0_ack_o : p1_ack_o;
      if (oth_ack) d_oth++;
      if (own_ack) begin
        d_acks++;
        d_rd = p ? p1_rd_o : p0_rd_o;
        d_err = err_o; d_grant = grant_o;
        d_exp_rd = p ? exp_p1_rd : exp_p0_rd;
        d_exp_err = exp_err;
        done = 1'b1;
      end
      mem_rdy_i  = strobe && (rdy_at != 0) && (d_strobes == rdy_at);
      mem_data_i = rdata;
    end
    chk("dir_ack_arrived", {31'd0, done}, 32'd1);
    tick();
    if (p) p1_req_i = 1'b0; else p0_req_i = 1'b0;
    mem_rdy_i = 1'b0;
  endtask

  task automatic rand_fields(input bit p);
    set_port(p, 1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)));
  endtask

  // ---------------- main stimulus ----------------
  int   nacks, gapc, maxgap, badown, stall;
  logic [3:0] gseq;
  bit   started, pd0, pd1, strobe;

  initial begin
    reset_i = 1'b1; mem_rdy_i = 1'b0; mem_data_i = '0;
    p0_req_i = 1'b0; p0_wr_i = 1'b0; p0_addr_i = '0; p0_wd_i = '0; p0_funct3_i = '0;
    p1_req_i = 1'b0; p1_wr_i = 1'b0; p1_addr_i = '0; p1_wd_i = '0; p1_funct3_i = '0;
    tick(); tick();
    chk_en = 1'b1;
    chk("reset_ctl", {26'd0, p0_ack_o, p1_ack_o, err_o, grant_o, mem_wr_o, mem_rd_o}, 32'd0);
    chk("reset_addr", mem_addr_o, 32'd0);
    reset_i = 1'b0;

    // core read, ready on the second ACCESS cycle
    dir_access(1'b0, 1'b0, 32'h40, 32'h0, 3'b010, 2, 32'h0000_0013);
    chk("d1_strobe_cycles", d_strobes, 32'd2);
    chk("d1_ack_pulses", d_acks, 32'd1);
    chk("d1_mrd_seen", {31'd0, d_rd_seen}, 32'd1);
    chk("d1_rd", d_rd, 32'h13);
    chk("d1_err", {31'd0, d_err}, 32'd0);
    chk("d1_model_pin_rd", d_exp_rd, 32'h13);

    // debug write
    dir_access(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'b010, 1, 32'hFFFF_FFFF);
    chk("d2_mwr_seen", {31'd0, d_wr_seen}, 32'd1);
    chk("d2_addr", d_addr, 32'h100);
    chk("d2_wd", d_wd, 32'hDEAD_BEEF);
    chk("d2_funct3", {29'd0, d_f3}, 32'd2);
    chk("d2_p1_rd", d_rd, 32'd0);
    chk("d2_grant", {31'd0, d_grant}, 32'd1);
    chk("d2_other_ack", d_oth, 32'd0);

    // watchdog expiry with ready stuck low
    dir_access(1'b0, 1'b0, 32'h44, 32'h0, 3'b010, 0, 32'h1234_5678);
    chk("d3_strobe_cycles", d_strobes, 32'd8);
    chk("d3_err", {31'd0, d_err}, 32'd1);
    chk("d3_rd", d_rd, 32'd0);
    chk("d3_model_pin_err", {31'd0, d_exp_err}, 32'd1);

    // both ports held high from reset: alternate grants starting with core
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    set_port(1'b0, 1'b0, 32'h200, 32'h0, 3'b010);
    set_port(1'b1, 1'b0, 32'h300, 32'h0, 3'b010);
    nacks = 0; gapc = 0; maxgap = 0; badown = 0; started = 1'b0; gseq = '0;
    for (int c = 0; c < 60 && nacks < 4; c++) begin
      tick();
      strobe = mem_rd_o | mem_wr_o;
      if (strobe) started = 1'b1;
      mem_rdy_i  = strobe;
      mem_data_i = $urandom;
      if (p0_ack_o || p1_ack_o) begin
        if ((p0_ack_o && p1_ack_o) || (p0_ack_o && grant_o) || (p1_ack_o && !grant_o)) badown++;
        gseq[3 - nacks] = grant_o;
        nacks++;
        gapc = 0;
      end else if (!strobe && started) begin
        gapc++;
        if (gapc > maxgap) maxgap = gapc;
      end else begin
        gapc = 0;
      end
    end
    tick();
    p0_req_i = 1'b0; p1_req_i = 1'b0; mem_rdy_i = 1'b0;
    chk("d4_ack_count", nacks, 32'd4);
    chk("d4_grant_seq", {28'd0, gseq}, 32'h5);
    chk("d4_ack_owner", badown, 32'd0);
    chk("d4_max_idle_gap", maxgap, 32'd1);

    // reset during ACCESS aborts the access, then a new request is served
    tick();
    set_port(1'b0, 1'b0, 32'h80, 32'h0, 3'b010);
    tick();
    chk("d5_in_access", {31'd0, mem_rd_o}, 32'd1);
    reset_i = 1'b1;
    tick();
    chk("d5_abort_ctl", {26'd0, p0_ack_o, p1_ack_o, err_o, grant_o, mem_wr_o, mem_rd_o}, 32'd0);
    reset_i = 1'b0;
    dir_access(1'b0, 1'b0, 32'h84, 32'h0, 3'b010, 1, 32'h0000_0055);
    chk("d5_ack_pulses", d_acks, 32'd1);
    chk("d5_rd", d_rd, 32'h55);

    // randomized traffic
    pd0 = 1'b0; pd1 = 1'b0; stall = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (stall > 0) begin
        stall--;
        mem_rdy_i = 1'b0;
      end else begin
        if ($urandom_range(0, 99) == 0) stall = 12;
        mem_rdy_i = ($urandom_range(0, 3) == 0);
      end
      mem_data_i = $urandom;
      reset_i = ($urandom_range(0, 399) == 0);
      if (reset_i) begin pd0 = 1'b0; pd1 = 1'b0; end
      if (pd0) begin
        pd0 = 1'b0;
        if ($urandom_range(0, 2) == 0) rand_fields(1'b0); else p0_req_i = 1'b0;
      end else if (!p0_req_i && $urandom_range(0, 3) == 0) begin
        rand_fields(1'b0);
      end
      if (pd1) begin
        pd1 = 1'b0;
        if ($urandom_range(0, 2) == 0) rand_fields(1'b1); else p1_req_i = 1'b0;
      end else if (!p1_req_i && $urandom_range(0, 3) == 0) begin
        rand_fields(1'b1);
      end
      if (p0_ack_o) pd0 = 1'b1;
      if (p1_ack_o) pd1 = 1'b1;
    end

    reset_i = 1'b0; p0_req_i = 1'b0; p1_req_i = 1'b0; mem_rdy_i = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
